// File: rtl/cnt_pkg.sv
// Shared types and helpers for the counter sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnt_pkg;

    // Width of the downstream synchronous counter
    localparam int CNT_W = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Load value that makes the counter hit terminal count after d clocks
    // (two's-complement negate; d == 0 encodes a full 16-clock period).
    function automatic logic [CNT_W-1:0] neg4(input logic [CNT_W-1:0] d);
        return {CNT_W{1'b0}} - d;
    endfunction

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// Request handshake plus counter control/status bundle for cnt_seq_ctrl.
// Latency: n/a (wiring only).
// Backpressure: REQ_READY from the sequencer gates REQ_VALID acceptance.
interface cnt_seq_ctrl_if
    import cnt_pkg::*;
#(
    parameter int REP_W = 8,
    parameter int DIV_W = CNT_W
);
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [DIV_W-1:0] REQ_DIV;
    logic [REP_W-1:0] REQ_REPS;
    logic             PAUSE;
    logic             TC;
    logic [DIV_W-1:0] P;
    logic             PE_N;
    logic             CEP;
    logic             CET;
    logic             TICK;
    logic             DONE;
    logic             BUSY;

    // Requester / counter side
    modport master (
        output REQ_VALID, REQ_DIV, REQ_REPS, PAUSE, TC,
        input  REQ_READY, P, PE_N, CEP, CET, TICK, DONE, BUSY
    );

    // Sequencer side
    modport slave (
        input  REQ_VALID, REQ_DIV, REQ_REPS, PAUSE, TC,
        output REQ_READY, P, PE_N, CEP, CET, TICK, DONE, BUSY
    );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Drives a 4-bit load/count block to produce REQ_REPS periods of REQ_DIV clocks, ticking per period.
// Latency: accept -> LOAD next cycle; TICK combinational from TC; DONE one cycle after the last TICK.
// Backpressure: REQ_READY only in IDLE; requests seen while busy are ignored, not queued.
module cnt_seq_ctrl
    import cnt_pkg::*;
#(
    parameter int REP_W = 8,
    parameter int DIV_W = 4
) (
    input  logic                CP,
    input  logic                SR,
    cnt_seq_ctrl_if.slave       bus
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [REP_W-1:0] rem_q,   rem_d;

    // State and run registers; synchronous reset overrides any accept
    always_ff @(posedge CP) begin
        if (SR) begin
            state_q <= IDLE;
            div_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state, repetition bookkeeping and counter control outputs
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        rem_d         = rem_q;
        bus.REQ_READY = 1'b0;
        bus.P         = neg4(div_q);
        bus.PE_N      = 1'b1;
        bus.CEP       = 1'b0;
        bus.CET       = 1'b0;
        bus.TICK      = 1'b0;
        bus.DONE      = 1'b0;
        bus.BUSY      = 1'b0;

        case (state_q)
            IDLE: begin
                bus.REQ_READY = 1'b1;
                if (bus.REQ_VALID) begin
                    div_d   = bus.REQ_DIV;
                    rem_d   = bus.REQ_REPS;
                    // A zero-repetition run skips the counter entirely
                    state_d = (bus.REQ_REPS != '0) ? LOAD : FIN;
                end
            end

            LOAD: begin
                bus.BUSY = 1'b1;
                bus.PE_N = 1'b0;
                state_d  = RUN;
            end

            RUN: begin
                bus.BUSY = 1'b1;
                // PAUSE gates CET, which also masks TC, so no reload or tick while frozen
                bus.CEP  = ~bus.PAUSE;
                bus.CET  = ~bus.PAUSE;
                // Reload on the terminal cycle so consecutive periods have no gap
                bus.PE_N = ~bus.TC;
                bus.TICK = bus.TC;
                if (bus.TC && (rem_q != '0)) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == REP_W'(1)) begin
                        state_d = FIN;
                    end
                end
            end

            FIN: begin
                bus.DONE = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
